// File: rtl/uart_line_packer_pkg.sv
// Shared constants, state encoding and group byte packing for the line packer.
package uart_line_packer_pkg;

  localparam logic [7:0] SYNC0       = 8'hA5;
  localparam logic [7:0] SYNC1       = 8'h5A;
  localparam int         GROUP_PIX   = 4;
  localparam int         GROUP_BYTES = 5;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_WAIT  = 3'd1;
  localparam logic [2:0] ST_HDR   = 3'd2;
  localparam logic [2:0] ST_FETCH = 3'd3;
  localparam logic [2:0] ST_SEND  = 3'd4;
  localparam logic [2:0] ST_CSUM  = 3'd5;
  localparam logic [2:0] ST_DONE  = 3'd6;

  typedef enum logic [2:0] {
    S_IDLE  = ST_IDLE,
    S_WAIT  = ST_WAIT,
    S_HDR   = ST_HDR,
    S_FETCH = ST_FETCH,
    S_SEND  = ST_SEND,
    S_CSUM  = ST_CSUM,
    S_DONE  = ST_DONE
  } state_t;

  typedef logic [GROUP_PIX-1:0][9:0] group_t;

  // Bytes 0..3 carry the pixel MSBs, byte 4 gathers the four 2-bit LSB fields.
  function automatic logic [7:0] group_byte(input group_t grp, input logic [2:0] idx);
    case (idx)
      3'd0:    group_byte = grp[0][9:2];
      3'd1:    group_byte = grp[1][9:2];
      3'd2:    group_byte = grp[2][9:2];
      3'd3:    group_byte = grp[3][9:2];
      3'd4:    group_byte = {grp[3][1:0], grp[2][1:0], grp[1][1:0], grp[0][1:0]};
      default: group_byte = 8'h00;
    endcase
  endfunction

endpackage

// File: rtl/uart_line_packer_issuer.sv
// Hands one byte at a time to uart_send; the guard blocks a second strobe until
// uart_send has visibly left idle, whatever its reaction latency.
module uart_byte_issuer (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       req_i,
  input  logic [7:0] byte_i,
  input  logic       tx_idle_i,
  output logic       ack_o,
  output logic [7:0] tx_data_o,
  output logic       tx_data_ready_o
);

  logic       guard_q, guard_d;
  logic [7:0] tx_data_q, tx_data_d;
  logic       tx_rdy_q, tx_rdy_d;
  logic       issue_s;

  assign issue_s = req_i & tx_idle_i & ~guard_q;

  // Issue decision and guard update.
  always_comb begin
    guard_d   = guard_q;
    tx_data_d = tx_data_q;
    tx_rdy_d  = 1'b0;
    if (issue_s) begin
      guard_d   = 1'b1;
      tx_data_d = byte_i;
      tx_rdy_d  = 1'b1;
    end else if (!tx_idle_i) begin
      guard_d = 1'b0;
    end else begin
      guard_d = guard_q;
    end
  end

  // Handshake registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      guard_q   <= 1'b0;
      tx_data_q <= 8'h00;
      tx_rdy_q  <= 1'b0;
    end else begin
      guard_q   <= guard_d;
      tx_data_q <= tx_data_d;
      tx_rdy_q  <= tx_rdy_d;
    end
  end

  assign ack_o           = issue_s;
  assign tx_data_o       = tx_data_q;
  assign tx_data_ready_o = tx_rdy_q;

endmodule

// File: rtl/uart_line_packer.sv
// Reads one buffered line, packs 10-bit pixels 4-into-5 bytes and frames them
// (sync, line number, payload, XOR checksum) for uart_send.
module uart_line_packer
  import uart_line_packer_pkg::*;
#(
  parameter int PIXELS    = 480,
  parameter int LINE_BITS = 10,
  parameter int ADDR_BITS = $clog2(PIXELS)
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 start_i,
  input  logic [LINE_BITS-1:0] line_number_i,
  input  logic                 ready_flag_i,
  output logic [ADDR_BITS-1:0] pixel_addr_o,
  input  logic [9:0]           pixel_data_i,
  output logic                 release_o,
  output logic [7:0]           tx_data_o,
  output logic                 tx_data_ready_o,
  input  logic                 tx_idle_i,
  output logic                 busy_o,
  output logic                 done_o
);

  state_t               state_q, state_d;
  logic [LINE_BITS-1:0] line_q, line_d;
  logic [ADDR_BITS-1:0] addr_q, addr_d;
  group_t               group_q, group_d;
  logic [2:0]           idx_q, idx_d;
  logic [2:0]           fetch_q, fetch_d;
  logic [7:0]           csum_q, csum_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic                 release_q, release_d;

  logic                 req_s;
  logic [7:0]           byte_s;
  logic                 ack_s;
  logic                 last_s;
  logic [15:0]          line16_s;
  logic [1:0]           slot_s;

  assign line16_s = 16'(line_q);
  assign last_s   = (addr_q == ADDR_BITS'(PIXELS - 1));
  // Data arriving on fetch step n belongs to the address driven on step n-1.
  assign slot_s   = fetch_q[1:0] - 2'd1;

  // Next-state and datapath control.
  always_comb begin
    state_d   = state_q;
    line_d    = line_q;
    addr_d    = addr_q;
    group_d   = group_q;
    idx_d     = idx_q;
    fetch_d   = fetch_q;
    csum_d    = csum_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    release_d = 1'b0;
    req_s     = 1'b0;
    byte_s    = 8'h00;
    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          line_d  = line_number_i;
          busy_d  = 1'b1;
          csum_d  = 8'h00;
          idx_d   = 3'd0;
          addr_d  = '0;
          state_d = S_WAIT;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_WAIT: begin
        if (ready_flag_i) begin
          state_d = S_HDR;
        end else begin
          state_d = S_WAIT;
        end
      end
      S_HDR: begin
        req_s = 1'b1;
        case (idx_q)
          3'd0:    byte_s = SYNC0;
          3'd1:    byte_s = SYNC1;
          3'd2:    byte_s = line16_s[15:8];
          default: byte_s = line16_s[7:0];
        endcase
        if (ack_s && (idx_q == 3'd3)) begin
          idx_d   = 3'd0;
          fetch_d = 3'd0;
          state_d = S_FETCH;
        end else if (ack_s) begin
          idx_d = idx_q + 3'd1;
        end else begin
          idx_d = idx_q;
        end
      end
      S_FETCH: begin
        if (fetch_q != 3'd0) begin
          group_d[slot_s] = pixel_data_i;
        end else begin
          group_d = group_q;
        end
        if (fetch_q < 3'(GROUP_PIX - 1)) begin
          addr_d = addr_q + 1'b1;
        end else begin
          addr_d = addr_q;
        end
        if (fetch_q == 3'(GROUP_PIX)) begin
          idx_d   = 3'd0;
          state_d = S_SEND;
        end else begin
          fetch_d = fetch_q + 3'd1;
        end
      end
      S_SEND: begin
        req_s  = 1'b1;
        byte_s = group_byte(group_q, idx_q);
        if (ack_s) begin
          csum_d = csum_q ^ byte_s;
          if (idx_q == 3'(GROUP_BYTES - 1)) begin
            idx_d = 3'd0;
            if (last_s) begin
              state_d = S_CSUM;
            end else begin
              addr_d  = addr_q + 1'b1;
              fetch_d = 3'd0;
              state_d = S_FETCH;
            end
          end else begin
            idx_d = idx_q + 3'd1;
          end
        end else begin
          csum_d = csum_q;
        end
      end
      S_CSUM: begin
        req_s  = 1'b1;
        byte_s = csum_q;
        if (ack_s) begin
          done_d    = 1'b1;
          release_d = 1'b1;
          busy_d    = 1'b0;
          state_d   = S_DONE;
        end else begin
          state_d = S_CSUM;
        end
      end
      S_DONE: begin
        addr_d  = '0;
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= S_IDLE;
      line_q    <= '0;
      addr_q    <= '0;
      group_q   <= '0;
      idx_q     <= 3'd0;
      fetch_q   <= 3'd0;
      csum_q    <= 8'h00;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      release_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      line_q    <= line_d;
      addr_q    <= addr_d;
      group_q   <= group_d;
      idx_q     <= idx_d;
      fetch_q   <= fetch_d;
      csum_q    <= csum_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      release_q <= release_d;
    end
  end

  uart_byte_issuer u_issuer (
    .clk_i           (clk_i),
    .rst_i           (rst_i),
    .req_i           (req_s),
    .byte_i          (byte_s),
    .tx_idle_i       (tx_idle_i),
    .ack_o           (ack_s),
    .tx_data_o       (tx_data_o),
    .tx_data_ready_o (tx_data_ready_o)
  );

  assign pixel_addr_o = addr_q;
  assign busy_o       = busy_q;
  assign done_o       = done_q;
  assign release_o    = release_q;

endmodule

// File: tb/tb_uart_line_packer.sv
// Bench for uart_line_packer: an 8-pixel instance for framing/handshake scenarios
// and a 480-pixel instance for a full random line, both checked against a byte model.
module tb_uart_line_packer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst = 1'b1;

  logic       a_start = 1'b0, a_ready = 1'b0, a_stall = 1'b0;
  logic [9:0] a_line = 10'd0, a_pdata;
  logic [2:0] a_addr;
  logic       a_rel, a_txr, a_idle, a_busy, a_done;
  logic [7:0] a_txd;

  logic       b_start = 1'b0, b_ready = 1'b0;
  logic [9:0] b_line = 10'd0, b_pdata;
  logic [8:0] b_addr;
  logic       b_rel, b_txr, b_idle, b_busy, b_done;
  logic [7:0] b_txd;

  uart_line_packer #(.PIXELS(8), .LINE_BITS(10)) dut_a (
    .clk_i(clk), .rst_i(rst), .start_i(a_start), .line_number_i(a_line),
    .ready_flag_i(a_ready), .pixel_addr_o(a_addr), .pixel_data_i(a_pdata),
    .release_o(a_rel), .tx_data_o(a_txd), .tx_data_ready_o(a_txr),
    .tx_idle_i(a_idle), .busy_o(a_busy), .done_o(a_done)
  );

  uart_line_packer #(.PIXELS(480), .LINE_BITS(10)) dut_b (
    .clk_i(clk), .rst_i(rst), .start_i(b_start), .line_number_i(b_line),
    .ready_flag_i(b_ready), .pixel_addr_o(b_addr), .pixel_data_i(b_pdata),
    .release_o(b_rel), .tx_data_o(b_txd), .tx_data_ready_o(b_txr),
    .tx_idle_i(b_idle), .busy_o(b_busy), .done_o(b_done)
  );

  // Line buffer: one-cycle read latency, shared pixel store.
  logic [9:0] pix [0:479];
  always @(posedge clk) begin
    a_pdata <= pix[a_addr];
    b_pdata <= pix[b_addr];
  end

  // uart_send model A: idle drops the cycle after a strobe and stays low 10 cycles.
  int         a_cnt = 0, a_strobes = 0, a_rel_cnt = 0, a_done_cnt = 0;
  logic [7:0] a_rx[$];
  always @(posedge clk) begin
    if (a_txr) begin
      a_rx.push_back(a_txd);
      a_strobes <= a_strobes + 1;
      a_cnt <= 10;
    end else if (a_cnt > 0) begin
      a_cnt <= a_cnt - 1;
    end
    if (a_rel)  a_rel_cnt  <= a_rel_cnt + 1;
    if (a_done) a_done_cnt <= a_done_cnt + 1;
  end
  assign a_idle = (a_cnt == 0) && !a_stall;

  // uart_send model B: random delay before idle falls, then 2 busy cycles.
  int         b_pre = 0, b_cnt = 0, b_done_cnt = 0;
  logic [8:0] b_addr_max = 9'd0;
  logic [7:0] b_rx[$];
  always @(posedge clk) begin
    if (b_txr) begin
      b_rx.push_back(b_txd);
      b_pre <= $urandom_range(0, 3);
      b_cnt <= 2;
    end else if (b_pre > 0) begin
      b_pre <= b_pre - 1;
    end else if (b_cnt > 0) begin
      b_cnt <= b_cnt - 1;
    end
    if (b_addr > b_addr_max) b_addr_max <= b_addr;
    if (b_done) b_done_cnt <= b_done_cnt + 1;
  end
  assign b_idle = !((b_pre == 0) && (b_cnt > 0));

  int checks = 0;
  int errors = 0;
  logic [7:0] exp_q[$];
  logic [7:0] lit [0:14] = '{8'hA5, 8'h5A, 8'h01, 8'h23, 8'hFF, 8'h00, 8'h00, 8'h80,
                             8'hE7, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h98};

  // Reference packet from the framing rules: header, 4-pixel groups, XOR of payload.
  task automatic build_expected(input int line, input int npix);
    int cs;
    int lo;
    exp_q.delete();
    exp_q.push_back(8'hA5);
    exp_q.push_back(8'h5A);
    exp_q.push_back(8'((line >> 8) & 255));
    exp_q.push_back(8'(line & 255));
    cs = 0;
    for (int g = 0; g < npix / 4; g++) begin
      lo = 0;
      for (int k = 0; k < 4; k++) begin
        int p;
        p = int'(pix[4*g+k]);
        exp_q.push_back(8'(p / 4));
        cs = cs ^ (p / 4);
        lo = lo + ((p % 4) << (2 * k));
      end
      exp_q.push_back(8'(lo));
      cs = cs ^ lo;
    end
    exp_q.push_back(8'(cs));
  endtask

  function automatic int stream_diff(input logic [7:0] got[$]);
    int bad = 0;
    if (got.size() != exp_q.size()) bad++;
    for (int i = 0; i < got.size() && i < exp_q.size(); i++)
      if (got[i] !== exp_q[i]) bad++;
    return bad;
  endfunction

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic fill_random(input int n);
    for (int i = 0; i < n; i++) pix[i] = 10'($urandom_range(0, 1023));
  endtask

  task automatic pulse_a_start(input logic [9:0] line);
    @(negedge clk);
    a_line  = line;
    a_start = 1'b1;
    @(negedge clk);
    a_start = 1'b0;
    a_line  = 10'($urandom_range(0, 1023));
  endtask

  task automatic wait_a_done(input int budget, output bit ok);
    int d0;
    d0 = a_done_cnt;
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (a_done_cnt != d0) begin
        ok = 1'b1;
        break;
      end
    end
    tick(3);
  endtask

  task automatic wait_a_bytes(input int n, input int budget);
    for (int i = 0; i < budget && a_rx.size() < n; i++) @(negedge clk);
  endtask

  task automatic test_reset;
    rst = 1'b1;
    tick(3);
    checks++; if (a_addr !== 3'd0) begin errors++; $display("FAIL reset_addr: got %0d expected 0", a_addr); end
    checks++; if (a_txd !== 8'h00) begin errors++; $display("FAIL reset_txdata: got %h expected 00", a_txd); end
    checks++; if (a_txr !== 1'b0) begin errors++; $display("FAIL reset_txready: got %b expected 0", a_txr); end
    checks++; if (a_rel !== 1'b0) begin errors++; $display("FAIL reset_release: got %b expected 0", a_rel); end
    checks++; if (a_busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", a_busy); end
    checks++; if (a_done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b expected 0", a_done); end
    rst = 1'b0;
    tick(2);
  endtask

  task automatic test_wait_ready;
    int s0;
    pix[0] = 10'h3FF; pix[1] = 10'h001; pix[2] = 10'h002; pix[3] = 10'h203;
    for (int i = 4; i < 8; i++) pix[i] = 10'h000;
    a_ready = 1'b0;
    a_rx.delete();
    s0 = a_strobes;
    pulse_a_start(10'd291);
    tick(20);
    checks++; if (a_busy !== 1'b1) begin errors++; $display("FAIL wait_busy: got %b expected 1", a_busy); end
    checks++; if (a_strobes != s0) begin errors++; $display("FAIL wait_no_strobe: got %0d strobes expected 0", a_strobes - s0); end
  endtask

  task automatic test_basic_packet;
    bit ok;
    int r0, d0, bad;
    r0 = a_rel_cnt; d0 = a_done_cnt;
    a_ready = 1'b1;
    wait_a_done(3000, ok);
    checks++; if (!ok) begin errors++; $display("FAIL basic_timeout: got no DONE expected DONE"); end
    bad = (a_rx.size() != 15) ? 1 : 0;
    for (int i = 0; i < 15 && i < a_rx.size(); i++) if (a_rx[i] !== lit[i]) bad++;
    checks++; if (bad != 0) begin errors++; $display("FAIL basic_bytes: got %0d bytes with %0d differences expected 15 matching", a_rx.size(), bad); end
    checks++; if (a_rel_cnt - r0 != 1) begin errors++; $display("FAIL basic_release: got %0d pulses expected 1", a_rel_cnt - r0); end
    checks++; if (a_done_cnt - d0 != 1) begin errors++; $display("FAIL basic_done: got %0d pulses expected 1", a_done_cnt - d0); end
    checks++; if (a_busy !== 1'b0) begin errors++; $display("FAIL basic_busy_end: got %b expected 0", a_busy); end
  endtask

  task automatic test_stall;
    bit ok;
    int s0;
    fill_random(8);
    a_rx.delete();
    pulse_a_start(10'd291);
    wait_a_bytes(3, 2000);
    a_stall = 1'b1;
    s0 = a_strobes;
    tick(200);
    checks++; if (a_strobes != s0) begin errors++; $display("FAIL stall_strobes: got %0d expected 0", a_strobes - s0); end
    checks++; if (a_rx.size() != 3) begin errors++; $display("FAIL stall_count: got %0d bytes expected 3", a_rx.size()); end
    a_stall = 1'b0;
    wait_a_done(3000, ok);
    build_expected(291, 8);
    checks++; if (!ok) begin errors++; $display("FAIL stall_timeout: got no DONE expected DONE"); end
    checks++; if (a_rx.size() != 15) begin errors++; $display("FAIL stall_total: got %0d bytes expected 15", a_rx.size()); end
    checks++; if (a_rx.size() > 3 && a_rx[3] !== 8'h23) begin errors++; $display("FAIL stall_resume: got %h expected 23", a_rx[3]); end
    checks++; if (stream_diff(a_rx) != 0) begin errors++; $display("FAIL stall_stream: got %0d differences expected 0", stream_diff(a_rx)); end
  endtask

  task automatic test_start_while_busy;
    bit ok;
    int line, r0, d0, s0;
    fill_random(8);
    a_rx.delete();
    line = $urandom_range(0, 1023);
    r0 = a_rel_cnt; d0 = a_done_cnt;
    pulse_a_start(10'(line));
    tick(5);
    pulse_a_start(10'(line ^ 10'h155));
    tick(40);
    pulse_a_start(10'(line ^ 10'h2AA));
    wait_a_done(3000, ok);
    build_expected(line, 8);
    checks++; if (!ok) begin errors++; $display("FAIL busy_timeout: got no DONE expected DONE"); end
    checks++; if (stream_diff(a_rx) != 0) begin errors++; $display("FAIL busy_stream: got %0d differences expected 0", stream_diff(a_rx)); end
    s0 = a_strobes;
    tick(60);
    checks++; if (a_strobes != s0) begin errors++; $display("FAIL busy_extra: got %0d extra strobes expected 0", a_strobes - s0); end
    checks++; if (a_done_cnt - d0 != 1) begin errors++; $display("FAIL busy_done: got %0d pulses expected 1", a_done_cnt - d0); end
    checks++; if (a_rel_cnt - r0 != 1) begin errors++; $display("FAIL busy_release: got %0d pulses expected 1", a_rel_cnt - r0); end
  endtask

  task automatic test_reset_mid;
    bit ok;
    int line, r0, d0;
    fill_random(8);
    a_rx.delete();
    pulse_a_start(10'($urandom_range(0, 1023)));
    wait_a_bytes(7, 3000);
    r0 = a_rel_cnt; d0 = a_done_cnt;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checks++; if (a_busy !== 1'b0) begin errors++; $display("FAIL rstmid_busy: got %b expected 0", a_busy); end
    checks++; if (a_addr !== 3'd0) begin errors++; $display("FAIL rstmid_addr: got %0d expected 0", a_addr); end
    tick(30);
    checks++; if (a_rel_cnt != r0 || a_done_cnt != d0) begin errors++; $display("FAIL rstmid_pulses: got %0d release %0d done expected 0 0", a_rel_cnt - r0, a_done_cnt - d0); end
    fill_random(8);
    a_rx.delete();
    line = $urandom_range(0, 1023);
    pulse_a_start(10'(line));
    wait_a_done(3000, ok);
    build_expected(line, 8);
    checks++; if (!ok) begin errors++; $display("FAIL rstmid_timeout: got no DONE expected DONE"); end
    checks++; if (stream_diff(a_rx) != 0) begin errors++; $display("FAIL rstmid_stream: got %0d differences expected 0", stream_diff(a_rx)); end
  endtask

  task automatic test_long_line;
    int line, d0;
    bit ok;
    fill_random(480);
    b_rx.delete();
    line = $urandom_range(0, 1023);
    d0 = b_done_cnt;
    b_ready = 1'b1;
    @(negedge clk);
    b_line  = 10'(line);
    b_start = 1'b1;
    @(negedge clk);
    b_start = 1'b0;
    b_line  = 10'($urandom_range(0, 1023));
    ok = 1'b0;
    for (int i = 0; i < 30000; i++) begin
      @(negedge clk);
      if (b_done_cnt != d0) begin ok = 1'b1; break; end
    end
    tick(3);
    build_expected(line, 480);
    checks++; if (!ok) begin errors++; $display("FAIL long_timeout: got no DONE expected DONE"); end
    checks++; if (b_rx.size() != 605) begin errors++; $display("FAIL long_count: got %0d bytes expected 605", b_rx.size()); end
    checks++; if (b_rx.size() == 605 && b_rx[604] !== exp_q[604]) begin errors++; $display("FAIL long_csum: got %h expected %h", b_rx[604], exp_q[604]); end
    checks++; if (stream_diff(b_rx) != 0) begin errors++; $display("FAIL long_stream: got %0d differences expected 0", stream_diff(b_rx)); end
    checks++; if (b_addr_max !== 9'd479) begin errors++; $display("FAIL long_addr_peak: got %0d expected 479", b_addr_max); end
    checks++; if (b_busy !== 1'b0) begin errors++; $display("FAIL long_busy_end: got %b expected 0", b_busy); end
  endtask

  initial begin
    for (int i = 0; i < 480; i++) pix[i] = 10'd0;
    test_reset;
    test_wait_ready;
    test_basic_packet;
    test_stall;
    test_start_while_busy;
    test_reset_mid;
    test_long_line;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_line_packer.md
Name: uart_line_packer

Overview:
Downstream stage between the line buffer and uart_send. On a START pulse it waits until the line buffer reports a complete line. It then reads the line pixel by pixel through the buffer's read port and packs the full 10-bit pixels into a framed byte stream for uart_send: sync bytes, line number, packed payload, XOR checksum. After the last byte it pulses RELEASE so the buffer can capture the next line.

Parameters:
PIXELS, 480, pixels per transmitted line; must be a multiple of 4
LINE_BITS, 10, width of the line number; must be ≤ 16
ADDR_BITS, $clog2(PIXELS), width of PIXEL_ADDR

Ports:
CLK  in  1  system clock
RST  in  1  synchronous, active-high reset
START  in  1  one-cycle request to send one line
LINE_NUMBER  in  LINE_BITS  line index; latched on accepted START
READY_FLAG  in  1  line buffer holds a complete line
PIXEL_ADDR  out  ADDR_BITS  line buffer read address
PIXEL_DATA  in  10  line buffer read data; valid 1 cycle after PIXEL_ADDR
RELEASE  out  1  one-cycle pulse: buffer may be refilled
TX_DATA  out  8  byte to uart_send
TX_DATA_READY  out  1  one-cycle strobe to uart_send
TX_IDLE  in  1  uart_send idle
BUSY  out  1  high from accepted START until DONE
DONE  out  1  one-cycle pulse after the checksum byte is issued

Behaviour:
- Reset: PIXEL_ADDR=0, TX_DATA=0, TX_DATA_READY=0, RELEASE=0, BUSY=0, DONE=0, state=S_IDLE, guard=0, checksum=0.
- RST mid-operation returns to S_IDLE in the next cycle. No RELEASE or DONE pulse is produced. A byte already handed to uart_send is not recalled.
- START is accepted only in S_IDLE. It is ignored while BUSY.
- Packet order:
  - 0xA5, 0x5A
  - line number high byte (zero-extended to 16 bits), then low byte
  - PIXELS/4 groups of 5 bytes
  - checksum byte
- Group format for pixels p0..p3:
  - bytes 0..3 = p0[9:2], p1[9:2], p2[9:2], p3[9:2]
  - byte 4 = {p3[1:0], p2[1:0], p1[1:0], p0[1:0]}
- Checksum = XOR of all payload bytes only (sync and line number bytes excluded).
- Byte issue rule:
  - Drive TX_DATA and a 1-cycle TX_DATA_READY only when TX_IDLE=1 and guard=0.
  - Set guard on issue. Clear guard when TX_IDLE is seen 0.
  - This tolerates any uart_send latency before IDLE falls.
- States:
  - S_IDLE: on START, latch LINE_NUMBER, BUSY=1, go to S_WAIT.
  - S_WAIT: go to S_HDR when READY_FLAG=1.
  - S_HDR: issue the 4 header bytes, then go to S_FETCH.
  - S_FETCH: drive 4 consecutive addresses on 4 cycles. Capture PIXEL_DATA one cycle after each into a 4×10 group register. This takes 5 cycles, then go to S_SEND.
  - S_SEND: issue the 5 group bytes, XORing each into the checksum. Then go to S_FETCH, or to S_CSUM if the group just sent was the last.
  - S_CSUM: issue the checksum, then go to S_DONE.
  - S_DONE: pulse RELEASE and DONE for one cycle. BUSY=0, PIXEL_ADDR=0, go to S_IDLE.
- PIXEL_ADDR increments by 1 across groups and never exceeds PIXELS-1. The counter is ADDR_BITS wide; "last group" means the address of p3 equals PIXELS-1.
- READY_FLAG is sampled only in S_WAIT. Dropping it mid-line has no effect.
- TX_IDLE held low stalls the FSM in the current byte state indefinitely. No bytes are lost or duplicated.

Decomposition:
- Shared package: sync constants SYNC0=8'hA5 and SYNC1=8'h5A; state encoding localparams; GROUP_PIX=4 and GROUP_BYTES=5.
- One natural sub-module: uart_byte_issuer. It implements the TX_IDLE/guard handshake with inputs req and byte, and output ack.

Test Plan:
1. Reset with PIXELS=8 → all outputs 0, BUSY=0. START with LINE_NUMBER=291 and READY_FLAG=0 → BUSY=1 and no TX_DATA_READY for 20 cycles.
2. PIXELS=8, LINE_NUMBER=291, READY_FLAG=1, pixels 0x3FF,0x001,0x002,0x203 then four 0x000, model uart_send with IDLE low for 10 cycles per byte → bytes A5 5A 01 23 FF 00 00 80 E7 00 00 00 00 00 98, then one RELEASE and one DONE pulse.
3. TX_IDLE held 0 for 200 cycles after the third byte → no strobes during the stall. On release the stream resumes at 0x23; the total is exactly 15 bytes.
4. START pulsed again while BUSY → ignored; a single 15-byte packet is produced.
5. RST asserted after the 7th byte → the next cycle has BUSY=0, and no RELEASE or DONE pulse. A following START produces a full, correct packet.
6. PIXELS=480, random pixel data → 2+2+600+1=605 bytes, checksum matches the model, PIXEL_ADDR peaks at 479.
